// File: rtl/secuenciador_bus_rtc.sv
// Access sequencer for a multiplexed-bus RTC: an address phase, then a data phase,
// then a recovery gap. Every phase is timed by one shared 4-bit counter.
// All outputs come from registers. The FSM state leads its outputs by one clock.
module secuenciador_bus_rtc #(
    parameter int unsigned T_SU  = 2,   // setup/hold phase length, 1..15
    parameter int unsigned T_ACC = 4,   // strobe width, 1..15
    parameter int unsigned T_REC = 7    // recovery length, 1..15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE, ADDR_SU, ADDR_STB, ADDR_HLD, DATA_SU, DATA_STB, DATA_HLD, RECOV
    } state_e;

    localparam logic [3:0] SU_M1  = 4'(T_SU - 1);
    localparam logic [3:0] ACC_M1 = 4'(T_ACC - 1);
    localparam logic [3:0] REC_M1 = 4'(T_REC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] len_m1;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       ad_n_q, ad_n_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q;

    // State, phase counter and request latches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: IDLE waits for start. Every other state runs for its own
    // length and then moves to the next state in a fixed order.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ADDR_STB, DATA_STB: len_m1 = ACC_M1;
            RECOV:              len_m1 = REC_M1;
            default:            len_m1 = SU_M1;
        endcase
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (start) begin
                state_d = ADDR_SU;
                rw_d    = rw;
                addr_d  = addr;
                wdata_d = wdata;
            end
        end else if (cnt_q == len_m1) begin
            cnt_d = '0;
            case (state_q)
                ADDR_SU:  state_d = ADDR_STB;
                ADDR_STB: state_d = ADDR_HLD;
                ADDR_HLD: state_d = DATA_SU;
                DATA_SU:  state_d = DATA_STB;
                DATA_STB: state_d = DATA_HLD;
                DATA_HLD: state_d = RECOV;
                default:  state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Bus outputs decoded from the current state. They are registered below,
    // so they appear one clock after the state.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        busy_d   = (state_q != IDLE);
        done_d   = 1'b0;
        case (state_q)
            ADDR_SU, ADDR_HLD: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
            end
            ADDR_STB: begin
                // The address is latched on wr_n for both reads and writes.
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
                wr_n_d   = 1'b0;
            end
            DATA_SU, DATA_HLD: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = !rw_q;
                ad_out_d = rw_q ? 8'h00 : wdata_q;
            end
            DATA_STB: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = !rw_q;
                ad_out_d = rw_q ? 8'h00 : wdata_q;
                if (rw_q) rd_n_d = 1'b0;
                else      wr_n_d = 1'b0;
            end
            RECOV:   done_d = (cnt_q == 4'd0);
            default: ;
        endcase
    end

    // Output registers. Read data is sampled when rd_n rises. At that edge the
    // RTC is still driving the bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            ad_n_q   <= ad_n_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (!rd_n_q && rd_n_d) rdata_q <= ad_in;
        end
    end

    assign cs_n   = cs_n_q;
    assign rd_n   = rd_n_q;
    assign wr_n   = wr_n_q;
    assign ad_n   = ad_n_q;
    assign ad_oe  = ad_oe_q;
    assign ad_out = ad_out_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_secuenciador_bus_rtc.sv
// Bench for secuenciador_bus_rtc. Each access pushes its expected cycle-by-cycle
// output trace into a queue. Each test task pops the queue at the falling edge
// and compares against the DUT. dut1 uses the default timing. dut2 uses 1/1/1.
module tb_secuenciador_bus_rtc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start1 = 0, rw1 = 0;
    logic [7:0] addr1 = 0, wdata1 = 0, ad_in1 = 0;
    logic       cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, busy1, done1;
    logic [7:0] ad_out1, rdata1;

    logic       start2 = 0, rw2 = 0;
    logic [7:0] addr2 = 0, wdata2 = 0, ad_in2 = 0;
    logic       cs_n2, rd_n2, wr_n2, ad_n2, ad_oe2, busy2, done2;
    logic [7:0] ad_out2, rdata2;

    secuenciador_bus_rtc dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start(start1), .rw(rw1), .addr(addr1),
        .wdata(wdata1), .ad_in(ad_in1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
        .ad_n(ad_n1), .ad_out(ad_out1), .ad_oe(ad_oe1), .rdata(rdata1),
        .busy(busy1), .done(done1)
    );

    secuenciador_bus_rtc #(.T_SU(1), .T_ACC(1), .T_REC(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start(start2), .rw(rw2), .addr(addr2),
        .wdata(wdata2), .ad_in(ad_in2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2),
        .ad_n(ad_n2), .ad_out(ad_out2), .ad_oe(ad_oe2), .rdata(rdata2),
        .busy(busy2), .done(done2)
    );

    // {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, done, ad_out, rdata}
    logic [22:0] obs1, obs2;
    assign obs1 = {cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, busy1, done1, ad_out1, rdata1};
    assign obs2 = {cs_n2, rd_n2, wr_n2, ad_n2, ad_oe2, busy2, done2, ad_out2, rdata2};

    typedef struct {
        int          cyc;
        logic [22:0] vec;
        logic        oe;   // ad_out is only compared while the bus is driven
    } exp_t;

    exp_t       sb1[$];
    exp_t       sb2[$];
    logic [7:0] rdm1 = 8'h00, rdm2 = 8'h00;
    int         n_cmp = 0, n_bad = 0;

    // Expected outputs for an access whose start is sampled at edge k. The trace
    // covers cycles k+1 .. k+total+1, and the last of those is the first IDLE cycle.
    task automatic push_access(input int which, input int k, input logic r,
                               input logic [7:0] a, input logic [7:0] wd,
                               input logic [7:0] adin, input int tsu,
                               input int tacc, input int trec);
        int         lens[7];
        int         tot, p, t;
        logic [7:0] rd;
        exp_t       e;
        lens = '{tsu, tacc, tsu, tsu, tacc, tsu, trec};
        tot  = 4 * tsu + 2 * tacc + trec;
        rd   = (which == 1) ? rdm1 : rdm2;
        for (int j = 1; j <= tot + 1; j++) begin
            t = j - 1;
            p = 0;
            while (p < 7 && t >= lens[p]) begin
                t = t - lens[p];
                p++;
            end
            if (r && p >= 5 && p <= 7) rd = adin;
            e.cyc = k + j;
            e.oe  = (p <= 2) || (p <= 5 && !r);
            e.vec = {(p >= 6), !(p == 4 && r), !(p == 1 || (p == 4 && !r)), (p > 2),
                     e.oe, (p != 7), (p == 6 && t == 0),
                     (p <= 2) ? a : wd, rd};
            if (which == 1) sb1.push_back(e);
            else            sb2.push_back(e);
        end
        if (which == 1) rdm1 = rd;
        else            rdm2 = rd;
    endtask

    task automatic push_idle(input int which, input int from, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.cyc = from + j;
            e.oe  = 1'b0;
            e.vec = {7'b1111000, 8'h00, (which == 1) ? rdm1 : rdm2};
            if (which == 1) sb1.push_back(e);
            else            sb2.push_back(e);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs1 !== {7'b1111000, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_dut1 got=%h want=%h", obs1, {7'b1111000, 16'h0000});
        end
        n_cmp++;
        if (obs2 !== {7'b1111000, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_dut2 got=%h want=%h", obs2, {7'b1111000, 16'h0000});
        end
    endtask

    // The reset release and start share one falling edge, so the first rising
    // edge after reset must already accept the request.
    task automatic test_write();
        int          k;
        exp_t        e;
        logic [22:0] m;
        @(negedge clk);
        rst_n = 1'b1; rw1 = 1'b0; addr1 = 8'h21; wdata1 = 8'h5A; start1 = 1'b1;
        k = cyc + 1;
        push_access(1, k, 1'b0, 8'h21, 8'h5A, ad_in1, 2, 4, 7);
        push_idle(1, k + 25, 3);
        while (cyc < k + 27) begin
            @(negedge clk);
            if (cyc == k) start1 = 1'b0;
            while (sb1.size() != 0 && sb1[0].cyc == cyc) begin
                e = sb1.pop_front();
                m = e.oe ? 23'h7FFFFF : 23'h7F00FF;
                n_cmp++;
                if ((obs1 & m) !== (e.vec & m)) begin
                    n_bad++;
                    $display("FAIL write cyc=k+%0d got=%h want=%h", cyc - k, obs1 & m, e.vec & m);
                end
            end
        end
    endtask

    task automatic test_read();
        int          k;
        exp_t        e;
        logic [22:0] m;
        @(negedge clk);
        rw1 = 1'b1; addr1 = 8'h07; wdata1 = 8'hEE; ad_in1 = 8'hC3; start1 = 1'b1;
        k = cyc + 1;
        push_access(1, k, 1'b1, 8'h07, 8'hEE, 8'hC3, 2, 4, 7);
        push_idle(1, k + 25, 2);
        while (cyc < k + 26) begin
            @(negedge clk);
            if (cyc == k) start1 = 1'b0;
            while (sb1.size() != 0 && sb1[0].cyc == cyc) begin
                e = sb1.pop_front();
                m = e.oe ? 23'h7FFFFF : 23'h7F00FF;
                n_cmp++;
                if ((obs1 & m) !== (e.vec & m)) begin
                    n_bad++;
                    $display("FAIL read cyc=k+%0d got=%h want=%h", cyc - k, obs1 & m, e.vec & m);
                end
            end
        end
    endtask

    // A second start at k+5 and input changes mid-access must have no effect.
    task automatic test_ignore_start();
        int          k, dones;
        exp_t        e;
        logic [22:0] m;
        dones = 0;
        @(negedge clk);
        rw1 = 1'b0; addr1 = 8'h3C; wdata1 = 8'h99; start1 = 1'b1;
        k = cyc + 1;
        push_access(1, k, 1'b0, 8'h3C, 8'h99, ad_in1, 2, 4, 7);
        push_idle(1, k + 25, 4);
        while (cyc < k + 28) begin
            @(negedge clk);
            if (cyc == k) begin
                start1 = 1'b0; rw1 = 1'b1; addr1 = 8'hFF; wdata1 = 8'h00;
            end
            if (cyc == k + 4) start1 = 1'b1;
            if (cyc == k + 5) start1 = 1'b0;
            if (done1 === 1'b1) dones++;
            while (sb1.size() != 0 && sb1[0].cyc == cyc) begin
                e = sb1.pop_front();
                m = e.oe ? 23'h7FFFFF : 23'h7F00FF;
                n_cmp++;
                if ((obs1 & m) !== (e.vec & m)) begin
                    n_bad++;
                    $display("FAIL ignore cyc=k+%0d got=%h want=%h", cyc - k, obs1 & m, e.vec & m);
                end
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL ignore_done_count got=%0d want=1", dones);
        end
    endtask

    // Reset is asserted between clock edges in the middle of the read strobe.
    task automatic test_reset_mid();
        int          k;
        exp_t        e;
        logic [22:0] m;
        @(negedge clk);
        rw1 = 1'b1; addr1 = 8'h55; ad_in1 = 8'hE7; start1 = 1'b1;
        k = cyc + 1;
        push_access(1, k, 1'b1, 8'h55, 8'h00, 8'hE7, 2, 4, 7);
        while (cyc < k + 11) begin
            @(negedge clk);
            if (cyc == k) start1 = 1'b0;
            while (sb1.size() != 0 && sb1[0].cyc == cyc) begin
                e = sb1.pop_front();
                m = e.oe ? 23'h7FFFFF : 23'h7F00FF;
                n_cmp++;
                if ((obs1 & m) !== (e.vec & m)) begin
                    n_bad++;
                    $display("FAIL rstmid cyc=k+%0d got=%h want=%h", cyc - k, obs1 & m, e.vec & m);
                end
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs1 !== {7'b1111000, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL rstmid_async got=%h want=%h", obs1, {7'b1111000, 16'h0000});
        end
        sb1.delete();
        rdm1 = 8'h00;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_hold done=%b busy=%b want 0/0", done1, busy1);
            end
        end
        rst_n = 1'b1;
    endtask

    // Start is held high on dut2, so a new access begins every 8 cycles.
    task automatic test_back_to_back();
        int          k;
        exp_t        e;
        logic [22:0] m;
        @(negedge clk);
        rw2 = 1'b0; addr2 = 8'h44; wdata2 = 8'h81; start2 = 1'b1;
        k = cyc + 1;
        for (int a = 0; a < 3; a++)
            push_access(2, k + 8 * a, 1'b0, 8'h44, 8'h81, ad_in2, 1, 1, 1);
        push_idle(2, k + 25, 3);
        while (cyc < k + 27) begin
            @(negedge clk);
            if (cyc == k + 16) start2 = 1'b0;
            while (sb2.size() != 0 && sb2[0].cyc == cyc) begin
                e = sb2.pop_front();
                m = e.oe ? 23'h7FFFFF : 23'h7F00FF;
                n_cmp++;
                if ((obs2 & m) !== (e.vec & m)) begin
                    n_bad++;
                    $display("FAIL b2b cyc=k+%0d got=%h want=%h", cyc - k, obs2 & m, e.vec & m);
                end
            end
        end
    endtask

    // Random accesses with noise on start/addr/wdata during each access. The
    // strobe invariants are checked every cycle.
    task automatic test_random();
        int          k, gap;
        logic        r;
        logic [7:0]  a, wd, di;
        exp_t        e;
        logic [22:0] m;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            r = 1'($urandom_range(0, 1));
            a = 8'($urandom); wd = 8'($urandom); di = 8'($urandom);
            gap = $urandom_range(0, 3);
            rw1 = r; addr1 = a; wdata1 = wd; ad_in1 = di; start1 = 1'b1;
            k = cyc + 1;
            push_access(1, k, r, a, wd, di, 2, 4, 7);
            while (cyc < k + 24 + gap) begin
                @(negedge clk);
                if (cyc >= k && cyc <= k + 20) begin
                    start1 = 1'($urandom_range(0, 1));
                    rw1 = 1'($urandom_range(0, 1));
                    addr1 = 8'($urandom); wdata1 = 8'($urandom);
                end
                if (cyc == k + 21) start1 = 1'b0;
                n_cmp++;
                if ((!rd_n1 && !wr_n1) || (cs_n1 && (!rd_n1 || !wr_n1))) begin
                    n_bad++;
                    $display("FAIL strobe_rule cyc=k+%0d cs_n=%b rd_n=%b wr_n=%b", cyc - k, cs_n1, rd_n1, wr_n1);
                end
                while (sb1.size() != 0 && sb1[0].cyc == cyc) begin
                    e = sb1.pop_front();
                    m = e.oe ? 23'h7FFFFF : 23'h7F00FF;
                    n_cmp++;
                    if ((obs1 & m) !== (e.vec & m)) begin
                        n_bad++;
                        $display("FAIL random cyc=k+%0d got=%h want=%h", cyc - k, obs1 & m, e.vec & m);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (sb1.size() != 0 || sb2.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations got=%0d/%0d want=0/0", sb1.size(), sb2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/secuenciador_bus_rtc.md
SECUENCIADOR_BUS_RTC -- requirements
Module: secuenciador_bus_rtc

Interface
REQ-001 The block SHALL have the parameter T_SU, default 2, giving setup/hold phase length in clk_i cycles (legal 1..15).
REQ-002 The block SHALL have the parameter T_ACC, default 4, giving the active-low strobe width in clk_i cycles (legal 1..15).
REQ-003 The block SHALL have the parameter T_REC, default 7, giving the bus recovery length in clk_i cycles (legal 1..15).
REQ-004 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have the port start, input, 1 bit: access request, sampled only in IDLE.
REQ-007 The block SHALL have the port rw, input, 1 bit: 1 = read, 0 = write, latched with start.
REQ-008 The block SHALL have the ports addr and wdata, input, 8 bits each: RTC register address and write data, latched with start.
REQ-009 The block SHALL have the port ad_in, input, 8 bits: multiplexed bus read-back from the RTC.
REQ-010 The block SHALL have the ports cs_n, rd_n, wr_n and ad_n, output, 1 bit each: chip select, read strobe, write strobe and address(0)/data(1) select; all active-low except ad_n.
REQ-011 The block SHALL have the ports ad_out, output, 8 bits, and ad_oe, output, 1 bit: bus drive value and tri-state enable.
REQ-012 The block SHALL have the ports rdata, output, 8 bits; busy, output, 1 bit; and done, output, 1 bit: captured read data, access in progress, and one-cycle completion pulse.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL use the states IDLE, ADDR_SU, ADDR_STB, ADDR_HLD, DATA_SU, DATA_STB, DATA_HLD and RECOV, visited in that order.
REQ-015 A 4-bit phase counter SHALL time each state: ADDR_SU, ADDR_HLD, DATA_SU and DATA_HLD last T_SU cycles; ADDR_STB and DATA_STB last T_ACC cycles; RECOV lasts T_REC cycles.
REQ-016 IDLE SHALL drive cs_n=1, rd_n=1, wr_n=1, ad_n=1, ad_oe=0, busy=0 and done=0.
REQ-017 start=1 sampled in IDLE at edge k SHALL latch rw, addr and wdata and enter ADDR_SU at k+1.
REQ-018 In ADDR_SU, ADDR_STB and ADDR_HLD, the block SHALL drive cs_n=0, ad_n=0, ad_oe=1 and ad_out=latched addr.
REQ-019 wr_n SHALL be 0 only in ADDR_STB during the address phase, for both reads and writes.
REQ-020 In DATA_SU, DATA_STB and DATA_HLD, the block SHALL drive cs_n=0 and ad_n=1.
REQ-021 For a write, the data phase SHALL drive ad_oe=1, ad_out=latched wdata, and wr_n=0 only in DATA_STB.
REQ-022 For a read, the data phase SHALL drive ad_oe=0, and rd_n=0 only in DATA_STB.
REQ-023 On a read, rdata SHALL load ad_in at the edge ending the last DATA_STB cycle and hold it until the next read; writes never alter rdata.
REQ-024 In RECOV, the block SHALL drive cs_n=1, rd_n=1, wr_n=1, ad_n=1 and ad_oe=0.
REQ-025 done SHALL be 1 only in the first RECOV cycle; after the last RECOV cycle the FSM SHALL return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start while busy=1 SHALL be ignored (no queueing), and input changes after latching SHALL not affect the access in progress.
REQ-028 rd_n and wr_n SHALL never be 0 simultaneously, and neither SHALL be 0 while cs_n=1.
REQ-029 Access timing with default parameters: start at edge k -> ADDR_STB k+3..k+6, DATA_STB k+11..k+14, done at k+17, busy=0 from k+24.
REQ-030 Back-to-back operation: start held high SHALL begin the next access in the first IDLE cycle after RECOV.

Reset
REQ-031 rst_ni=0 SHALL immediately, regardless of edge or state (including mid-strobe), force IDLE, cs_n=rd_n=wr_n=ad_n=1, ad_oe=0, ad_out=0x00, rdata=0x00, busy=0, done=0, and clear the counter and latches.
REQ-032 After rst_ni rises, start SHALL be honoured from the first clk_i edge.

Verification
REQ-033 Write, addr=0x21, wdata=0x5A, defaults -> wr_n low at k+3..k+6 with ad_out=0x21 and ad_n=0; wr_n low at k+11..k+14 with ad_out=0x5A and ad_n=1; done at k+17; rdata unchanged.
REQ-034 Read, addr=0x07, ad_in=0xC3 -> rd_n low at k+11..k+14 with ad_oe=0; rdata=0xC3 from k+15; done at k+17; wr_n low only at k+3..k+6.
REQ-035 start pulsed at k+5 during the access -> ignored; exactly one done pulse; busy falls at k+24.
REQ-036 rst_ni driven low at k+12, mid DATA_STB -> all strobes high and busy=0 without waiting for a clock edge; no done pulse.
REQ-037 T_SU=1, T_ACC=1, T_REC=1 with start held high -> each strobe low exactly 1 cycle; accesses repeat every 8 cycles.
REQ-038 Randomised accesses -> REQ-028 holds every cycle.
